// File: rtl/adc_scan_ctrl_pkg.sv
// Shared types and constants for the ADC0809-class scan controller.
package adc_scan_pkg;

  localparam int ADC_DW = 8;
  localparam int ADC_AW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_READ,
    S_NEXT
  } state_t;

  // Width of a counter that must hold values 0..timeout.
  function automatic int to_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// ADC pin bundle plus the valid/ready result stream of the scan controller.
interface adc_scan_ctrl_if;
  import adc_scan_pkg::*;

  logic              ale;
  logic              start;
  logic              oe;
  logic [ADC_AW-1:0] addr;
  logic              eoc;
  logic [ADC_DW-1:0] adc_d;

  logic [ADC_DW-1:0] res_data;
  logic [ADC_AW-1:0] res_ch;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output ale, start, oe, addr, res_data, res_ch, res_valid,
    input  eoc, adc_d, res_ready
  );

  modport slave (
    input  ale, start, oe, addr, res_data, res_ch, res_valid,
    output eoc, adc_d, res_ready
  );

endinterface

// File: rtl/adc_result_slot.sv
// One-entry valid/ready holding register for a conversion result and its channel.
module adc_result_slot
  import adc_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADC_DW-1:0] load_data,
  input  logic [ADC_AW-1:0] load_ch,
  input  logic              ready,
  output logic              valid,
  output logic              free,
  output logic [ADC_DW-1:0] data,
  output logic [ADC_AW-1:0] ch
);

  // Slot can take a new result if empty or being drained this cycle.
  assign free = !valid || ready;

  // A load in the same cycle as a drain keeps the slot full with the new entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      ch    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ch    <= load_ch;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel scan controller for ADC0809-class converters.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   S_IDLE    | pins low, channel pointer held at 0, wait for en
//   S_ADDR    | ale high for one cycle, mux address latched
//   S_START   | start high for START_W cycles
//   S_WAIT_LO | wait for eoc to fall (conversion running)
//   S_WAIT_HI | wait for eoc to rise (conversion done)
//   S_READ    | oe high, wait for a free result slot, capture adc_d
//   S_NEXT    | advance channel pointer, resample en
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int START_W = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  adc_scan_ctrl_if.master   bus,
  output logic              timeout_err,
  output logic [ADC_AW-1:0] err_ch
);

  localparam int                TO_W    = to_w(TIMEOUT);
  localparam int                SW_W    = $clog2(START_W + 1);
  localparam logic [ADC_AW-1:0] LAST_CH = ADC_AW'(NCH - 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [SW_W-1:0]   SW_LOAD = SW_W'(START_W - 1);

  state_t            state, state_nxt;
  logic [ADC_AW-1:0] ch_ptr;
  logic [SW_W-1:0]   sw_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              slot_free;
  logic              slot_load;
  logic              to_hit;

  // Pin outputs are pure state decodes so nothing combinational reaches them.
  assign bus.ale   = (state == S_ADDR);
  assign bus.start = (state == S_START);
  assign bus.oe    = (state == S_READ);
  assign bus.addr  = ch_ptr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; an expired EOC wait wins over an eoc edge in the same cycle.
  always_comb begin
    state_nxt = state;
    slot_load = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE:  if (en) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_START;
      S_START: if (sw_cnt == '0) state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (to_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = S_NEXT;
        end else if (!bus.eoc) begin
          state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (to_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = S_NEXT;
        end else if (bus.eoc) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (slot_free) begin
          slot_load = 1'b1;
          state_nxt = S_NEXT;
        end
      end
      S_NEXT:  state_nxt = en ? S_ADDR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // START pulse width timer: loaded in ADDR, counts down to terminal zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                sw_cnt <= '0;
    else if (state == S_ADDR)                  sw_cnt <= SW_LOAD;
    else if (state == S_START && sw_cnt != '0) sw_cnt <= sw_cnt - 1'b1;
  end

  // EOC wait timer: zero outside the wait states, so it starts at 0 in WAIT_LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         to_cnt <= '0;
    else if (state == S_WAIT_LO || state == S_WAIT_HI)  to_cnt <= to_cnt + 1'b1;
    else                                                to_cnt <= '0;
  end

  // Channel pointer: cleared while idle, wraps after the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ch_ptr <= '0;
    else if (state == S_IDLE)   ch_ptr <= '0;
    else if (state == S_NEXT)   ch_ptr <= (ch_ptr == LAST_CH) ? '0 : ch_ptr + 1'b1;
  end

  // Timeout pulse and sticky channel of the last timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
      err_ch      <= '0;
    end else begin
      timeout_err <= to_hit;
      if (to_hit) err_ch <= ch_ptr;
    end
  end

  adc_result_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .load_data (bus.adc_d),
    .load_ch   (ch_ptr),
    .ready     (bus.res_ready),
    .valid     (bus.res_valid),
    .free      (slot_free),
    .data      (bus.res_data),
    .ch        (bus.res_ch)
  );

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: a 4-channel instance with a behavioural
// ADC and a single-channel instance running alongside it.
module tb_adc_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic       to_err_a, to_err_b;
  logic [2:0] err_ch_a, err_ch_b;
  logic       stuck;

  int total = 0;
  int bad   = 0;
  int popped_a = 0;
  int popped_b = 0;
  int to_pulses = 0;
  bit done_b = 0;

  logic [10:0] qa[$];
  logic [10:0] qb[$];

  adc_scan_ctrl_if ifa();
  adc_scan_ctrl_if ifb();

  adc_scan_ctrl #(.NCH(4), .START_W(2), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .bus(ifa),
    .timeout_err(to_err_a), .err_ch(err_ch_a)
  );

  adc_scan_ctrl #(.NCH(1), .START_W(1), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .bus(ifb),
    .timeout_err(to_err_b), .err_ch(err_ch_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] exp_of(input logic [2:0] ch);
    logic [7:0] d;
    d = 8'h40 + {5'd0, ch};
    return {ch, d};
  endfunction

  task automatic check_all_zero_a(input string tag);
    check({tag, "_ale"}, ifa.ale, 0);
    check({tag, "_start"}, ifa.start, 0);
    check({tag, "_oe"}, ifa.oe, 0);
    check({tag, "_addr"}, ifa.addr, 0);
    check({tag, "_res_data"}, ifa.res_data, 0);
    check({tag, "_res_ch"}, ifa.res_ch, 0);
    check({tag, "_res_valid"}, ifa.res_valid, 0);
    check({tag, "_timeout_err"}, to_err_a, 0);
    check({tag, "_err_ch"}, err_ch_a, 0);
  endtask

  // ADC model A: eoc low 3..9 cycles after start rises, data = 0x40 + channel.
  initial begin
    int  t;
    logic sp;
    t = 100; sp = 1'b0;
    ifa.eoc = 1'b1; ifa.adc_d = 8'h00;
    forever begin
      tick();
      if (ifa.start && !sp) t = 0;
      else if (t < 100) t++;
      sp = ifa.start;
      ifa.eoc   = (stuck && ifa.addr == 3'd2) ? 1'b1 : !(t >= 3 && t < 10);
      ifa.adc_d = 8'h40 + {5'd0, ifa.addr};
    end
  end

  // ADC model B, same timing.
  initial begin
    int  t;
    logic sp;
    t = 100; sp = 1'b0;
    ifb.eoc = 1'b1; ifb.adc_d = 8'h00;
    forever begin
      tick();
      if (ifb.start && !sp) t = 0;
      else if (t < 100) t++;
      sp = ifb.start;
      ifb.eoc   = !(t >= 3 && t < 10);
      ifb.adc_d = 8'h40 + {5'd0, ifb.addr};
    end
  end

  // Scoreboard monitors: pop on every accepted result.
  always @(negedge clk) begin
    if (rst_n && ifa.res_valid && ifa.res_ready) begin
      if (qa.size() == 0) begin
        check("a_unexpected_result", {21'd0, ifa.res_ch, ifa.res_data}, 32'hFFFF_FFFF);
      end else begin
        check("a_result", {21'd0, ifa.res_ch, ifa.res_data}, {21'd0, qa.pop_front()});
      end
      popped_a++;
    end
    if (rst_n && ifb.res_valid && ifb.res_ready) begin
      if (qb.size() == 0) begin
        check("b_unexpected_result", {21'd0, ifb.res_ch, ifb.res_data}, 32'hFFFF_FFFF);
      end else begin
        check("b_result", {21'd0, ifb.res_ch, ifb.res_data}, {21'd0, qb.pop_front()});
      end
      popped_b++;
    end
    if (rst_n && ifb.ale) check("b_addr", ifb.addr, 0);
  end

  // Pulse width and timeout monitors on instance A.
  always @(negedge clk) begin
    int ale_w, st_w;
    if (!rst_n) begin
      ale_w = 0; st_w = 0;
    end else begin
      if (ifa.ale) ale_w++;
      else if (ale_w != 0) begin check("ale_width", ale_w, 1); ale_w = 0; end
      if (ifa.start) st_w++;
      else if (st_w != 0) begin check("start_width", st_w, 2); st_w = 0; end
      if (to_err_a) begin
        to_pulses++;
        check("err_ch_on_pulse", err_ch_a, 2);
      end
    end
  end

  // Single-channel instance: three conversions then idle.
  initial begin
    int n, rises;
    logic ap;
    en_b = 1'b0;
    ifb.res_ready = 1'b1;
    @(posedge rst_n);
    tick();
    qb.push_back(exp_of(3'd0));
    qb.push_back(exp_of(3'd0));
    qb.push_back(exp_of(3'd0));
    en_b = 1'b1;
    rises = 0; ap = 1'b0; n = 0;
    while (rises < 3 && n < 500) begin
      tick();
      if (ifb.ale && !ap) rises++;
      ap = ifb.ale;
      n++;
    end
    check("b_wait_ale", n < 500, 1);
    en_b = 1'b0;
    n = 0;
    while (popped_b < 3 && n < 500) begin tick(); n++; end
    check("b_wait_results", n < 500, 1);
    done_b = 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int n, cnt;
    rst_n = 1'b0; en_a = 1'b0; stuck = 1'b0;
    ifa.res_ready = 1'b1;
    repeat (3) tick();
    check_all_zero_a("reset");
    rst_n = 1'b1;
    tick();

    // Normal scan with wrap back to channel 0.
    qa.push_back(exp_of(3'd0));
    qa.push_back(exp_of(3'd1));
    qa.push_back(exp_of(3'd2));
    qa.push_back(exp_of(3'd3));
    qa.push_back(exp_of(3'd0));
    en_a = 1'b1;
    n = 0;
    while (popped_a < 5 && n < 1000) begin tick(); n++; end
    check("wait_scan5", n < 1000, 1);

    // Drop en during WAIT_HI of channel 1: result still delivered, then idle.
    qa.push_back(exp_of(3'd1));
    n = 0;
    while (!(ifa.addr == 3'd1 && !ifa.eoc) && n < 200) begin tick(); n++; end
    check("wait_ch1_eoc_low", n < 200, 1);
    tick();
    en_a = 1'b0;
    n = 0;
    while (popped_a < 6 && n < 200) begin tick(); n++; end
    check("wait_ch1_result", n < 200, 1);
    cnt = 0;
    repeat (20) begin tick(); if (ifa.ale) cnt++; end
    check("idle_no_ale", cnt, 0);
    check("idle_addr", ifa.addr, 0);

    // Back-pressure: hold the first result for 20 cycles.
    ifa.res_ready = 1'b0;
    qa.push_back(exp_of(3'd0));
    qa.push_back(exp_of(3'd1));
    en_a = 1'b1;
    n = 0;
    while (!ifa.res_valid && n < 200) begin tick(); n++; end
    check("wait_bp_valid", n < 200, 1);
    repeat (20) tick();
    check("bp_valid_held", ifa.res_valid, 1);
    check("bp_data_held", ifa.res_data, 8'h40);
    check("bp_ch_held", ifa.res_ch, 0);
    check("bp_stall_oe", ifa.oe, 1);
    check("bp_stall_addr", ifa.addr, 1);
    ifa.res_ready = 1'b1;
    tick();
    check("bp_refill_valid", ifa.res_valid, 1);
    check("bp_refill_ch", ifa.res_ch, 1);
    en_a = 1'b0;
    repeat (20) tick();
    check("bp_popped", popped_a, 8);

    // Timeout on channel 2 with eoc stuck high.
    stuck = 1'b1;
    qa.push_back(exp_of(3'd0));
    qa.push_back(exp_of(3'd1));
    qa.push_back(exp_of(3'd3));
    en_a = 1'b1;
    n = 0;
    while (!(ifa.ale && ifa.addr == 3'd3) && n < 1000) begin tick(); n++; end
    check("wait_ch3_addr", n < 1000, 1);
    en_a = 1'b0;
    n = 0;
    while (qa.size() != 0 && n < 200) begin tick(); n++; end
    check("wait_timeout_scan", n < 200, 1);
    repeat (10) tick();
    check("timeout_pulses", to_pulses, 1);
    check("err_ch_hold", err_ch_a, 2);
    stuck = 1'b0;

    n = 0;
    while (!done_b && n < 1000) begin tick(); n++; end
    check("wait_b_done", n < 1000, 1);

    // Asynchronous reset during START.
    en_a = 1'b1;
    n = 0;
    while (!ifa.start && n < 100) begin tick(); n++; end
    check("wait_start", n < 100, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero_a("rst_start");
    en_a = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (ifa.ale) cnt++; end
    check("rst_start_idle", cnt, 0);

    // Asynchronous reset while stalled in READ.
    ifa.res_ready = 1'b0;
    en_a = 1'b1;
    n = 0;
    while (!(ifa.oe && ifa.res_valid && ifa.addr == 3'd1) && n < 300) begin tick(); n++; end
    check("wait_read_stall", n < 300, 1);
    check("stall_data", ifa.res_data, 8'h40);
    rst_n = 1'b0;
    #1;
    check_all_zero_a("rst_read");
    en_a = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    ifa.res_ready = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (ifa.ale || ifa.res_valid) cnt++; end
    check("rst_read_idle", cnt, 0);

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    check("b_popped", popped_b, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
